mc_req_queue: RTL and testbench

Front-end request stage of the DDR5 memory controller. Accepts CPU trace requests (core, operation, 34-bit physical address) over a valid/ready handshake, validates them, and decodes the address into DDR5 fields. Stamps each request with the arrival cycle and buffers it in a 16-entry in-order queue. The queue feeds the DIMM command scheduler, which pops one request at a time to issue ACT/RD/WR/PRE.

---
 rtl/mc_pkg.sv | 49 ++++
 rtl/mc_sync_fifo.sv | 73 +++++++
 rtl/mc_req_queue.sv | 92 +++++++++
 tb/tb_mc_req_queue.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared DDR5 request types and address decode, used by the request
// queue and by the DIMM command scheduler.
package mc_pkg;

    localparam int ADDR_W   = 34;
    localparam int CORE_W   = 4;
    localparam int BG_W     = 3;
    localparam int BANK_W   = 2;
    localparam int ROW_W    = 16;
    localparam int COL_W    = 10;
    localparam int CYC_W    = 64;
    localparam int CH_BIT   = 6;

    // Encoding 2'd3 is illegal and never enters the queue.
    typedef enum logic [1:0] {
        RD     = 2'd0,
        WR     = 2'd1,
        IFETCH = 2'd2
    } opn_t;

    typedef struct packed {
        logic [CORE_W-1:0] core;
        opn_t              opn;
        logic [1:0]        byte_select;
        logic              channel;
        logic [BG_W-1:0]   bank_group;
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  column;
        logic [ADDR_W-1:0] addr;
        logic [CYC_W-1:0]  arr_cyc;
    } req_t;

    // Splits a physical address into DDR5 fields; core, opn and arr_cyc
    // are left zero for the caller to fill in.
    function automatic req_t decode_addr(input logic [ADDR_W-1:0] addr);
        req_t r;
        r             = '0;
        r.byte_select = addr[1:0];
        r.channel     = addr[CH_BIT];
        r.bank_group  = addr[9:7];
        r.bank        = addr[11:10];
        r.row         = addr[33:18];
        r.column      = {addr[17:12], addr[5:2]};
        r.addr        = addr;
        return r;
    endfunction

endpackage

// File: rtl/mc_sync_fifo.sv
// Generic in-order FIFO with combinational head read. Storage is not
// reset; only pointers and occupancy are.
module mc_sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  T                       data_i,
    input  logic                   pop_i,
    output T                       data_o,
    output logic                   valid_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign valid_o = (count_q != '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && valid_o;
    assign data_o  = mem[rd_ptr_q];

    // Next-state pointers (wrap naturally, DEPTH is a power of two) and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards all entries at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mc_req_queue.sv
// Front-end request stage: validates CPU requests, decodes the address,
// stamps the arrival cycle and queues legal requests for the scheduler.
// Illegal requests are consumed and counted instead of queued.
module mc_req_queue
    import mc_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int MAX_CORE = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CORE_W-1:0]      in_core,
    input  logic [1:0]             in_opn,
    input  logic [ADDR_W-1:0]      in_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output req_t                   out_req,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   drop_pulse,
    output logic [15:0]            drop_cnt,
    output logic [63:0]            cycle
);

    localparam logic [CORE_W-1:0] MAX_CORE_L = CORE_W'(MAX_CORE);

    logic        illegal;
    logic        accept;
    logic        push;
    req_t        push_req;
    logic [63:0] cycle_q, cycle_d;
    logic        drop_pulse_q, drop_pulse_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign illegal    = (in_core > MAX_CORE_L) || (in_opn == 2'd3) || in_addr[CH_BIT];
    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready   = !full;
    assign accept     = in_valid && in_ready;
    assign push       = accept && !illegal;
    assign cycle      = cycle_q;
    assign drop_pulse = drop_pulse_q;
    assign drop_cnt   = drop_cnt_q;

    // Build the queued entry: decoded address plus requester info and timestamp.
    always_comb begin
        push_req         = decode_addr(in_addr);
        push_req.core    = in_core;
        push_req.opn     = opn_t'(in_opn);
        push_req.arr_cyc = cycle_q;
    end

    // Next-state for the cycle counter and drop accounting (saturating).
    always_comb begin
        cycle_d      = cycle_q + 64'd1;
        drop_pulse_d = accept && illegal;
        drop_cnt_d   = drop_cnt_q;
        if (accept && illegal && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Counter and drop registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q      <= '0;
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            cycle_q      <= cycle_d;
            drop_pulse_q <= drop_pulse_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    mc_sync_fifo #(
        .T     (req_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_req),
        .pop_i   (out_ready),
        .data_o  (out_req),
        .valid_o (out_valid),
        .full_o  (full),
        .count_o (count)
    );

endmodule

// File: tb/tb_mc_req_queue.sv
// Randomized plus directed bench for mc_req_queue. A queue-based model
// predicts every output; a negedge monitor compares DUT against it.
module tb_mc_req_queue;
    import mc_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  in_core = '0;
    logic [1:0]  in_opn = '0;
    logic [33:0] in_addr = '0;
    logic        in_ready, out_valid, full, drop_pulse;
    req_t        out_req;
    logic [4:0]  count;
    logic [15:0] drop_cnt;
    logic [63:0] cycle;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    req_t            exp_q[$];
    longint unsigned mdl_cycle = 0;
    logic [15:0]     mdl_drop = '0;
    bit              mdl_dp = 0;
    bit              mdl_acc = 0;
    bit              chk_en = 0;
    bit              m_rdy, m_acc, m_bad;
    req_t            m_pop;

    mc_req_queue #(.DEPTH(DEPTH), .MAX_CORE(11)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_core    (in_core),
        .in_opn     (in_opn),
        .in_addr    (in_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_req    (out_req),
        .count      (count),
        .full       (full),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt),
        .cycle      (cycle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_req(input string name, input req_t act, input req_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected entry from plain arithmetic on the address.
    function automatic req_t make_exp(input logic [3:0] c, input logic [1:0] o,
                                      input logic [33:0] a, input longint unsigned t);
        req_t            r;
        longint unsigned av;
        av            = 64'(a);
        r.core        = c;
        r.opn         = opn_t'(o);
        r.byte_select = 2'(av % 4);
        r.channel     = 1'((av / 64) % 2);
        r.bank_group  = 3'((av / 128) % 8);
        r.bank        = 2'((av / 1024) % 4);
        r.row         = 16'(av / 262144);
        r.column      = 10'(((av / 4096) % 64) * 16 + (av / 4) % 16);
        r.addr        = a;
        r.arr_cyc     = t;
        return r;
    endfunction

    function automatic logic [33:0] rand_addr(input bit ch);
        logic [63:0] w;
        logic [33:0] a;
        w    = {32'($urandom()), 32'($urandom())};
        a    = w[33:0];
        a[6] = ch;
        return a;
    endfunction

    // Model update at each clock edge: pop, then push/drop, then count cycles.
    always @(posedge clk) begin
        if (rst_n) begin
            m_rdy = (exp_q.size() < DEPTH);
            m_acc = in_valid && m_rdy;
            m_bad = (in_core > 4'd11) || (in_opn == 2'd3) || in_addr[6];
            if (out_ready && exp_q.size() > 0) begin
                m_pop = exp_q.pop_front();
                $display("[TB] pop core=%0d opn=%0d addr=%h arr_cyc=%0d",
                         m_pop.core, m_pop.opn, m_pop.addr, m_pop.arr_cyc);
            end
            if (m_acc && !m_bad) begin
                exp_q.push_back(make_exp(in_core, in_opn, in_addr, mdl_cycle));
            end
            mdl_dp = m_acc && m_bad;
            if (m_acc && m_bad && mdl_drop != 16'hFFFF) mdl_drop++;
            mdl_acc   = m_acc;
            mdl_cycle = mdl_cycle + 1;
        end
    end

    // Monitor: compares all DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) chk_req("out_req", out_req, exp_q[0]);
            chk("count", 64'(count), 64'(exp_q.size()));
            chk("full", 64'(full), 64'(exp_q.size() == DEPTH));
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
            chk("drop_pulse", 64'(drop_pulse), 64'(mdl_dp));
            chk("drop_cnt", 64'(drop_cnt), 64'(mdl_drop));
            chk("cycle", cycle, mdl_cycle);
        end
    end

    // Hold a request until the model says it was accepted; leaves in_valid high.
    task automatic send(input logic [3:0] c, input logic [1:0] o, input logic [33:0] a);
        int tries;
        tries    = 0;
        in_valid = 1'b1;
        in_core  = c;
        in_opn   = o;
        in_addr  = a;
        do begin
            @(posedge clk);
            #1;
            tries++;
        end while (!mdl_acc && tries < 200);
        if (!mdl_acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
        end
    endtask

    initial begin
        longint unsigned t_acc;

        // Reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1;
        @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);

        // Single directed read
        send(4'd2, 2'd0, 34'h0_1234_5680);
        t_acc    = mdl_cycle - 1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("dir_valid", 64'(out_valid), 64'd1);
        chk("dir_bg", 64'(out_req.bank_group), 64'd5);
        chk("dir_bank", 64'(out_req.bank), 64'd1);
        chk("dir_row", 64'(out_req.row), 64'h048D);
        chk("dir_col", 64'(out_req.column), 64'h050);
        chk("dir_ch", 64'(out_req.channel), 64'd0);
        chk("dir_arr", out_req.arr_cyc, t_acc);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;

        // Fill to full, 17th held until a pop
        for (int k = 0; k < 16; k++) send(4'(k % 12), 2'(k % 3), rand_addr(1'b0));
        in_core = 4'd7; in_opn = 2'd1; in_addr = rand_addr(1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("full16", 64'(full), 64'd1);
            chk("ready16", 64'(in_ready), 64'd0);
            chk("count16", 64'(count), 64'd16);
        end
        out_ready = 1'b1;
        send(in_core, in_opn, in_addr);
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("drained", 64'(count), 64'd0);
        out_ready = 1'b0;

        // Three illegal requests back to back
        send(4'd12, 2'd0, rand_addr(1'b0));
        send(4'd0, 2'd3, rand_addr(1'b0));
        send(4'd1, 2'd0, rand_addr(1'b1));
        in_valid = 1'b0;
        @(negedge clk);
        chk("drop3", 64'(drop_cnt), 64'd3);
        chk("drop_noq", 64'(count), 64'd0);

        // Push and pop together at count 8
        for (int k = 0; k < 8; k++) send(4'(k), 2'd2, rand_addr(1'b0));
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            send(4'(k % 12), 2'(k % 3), rand_addr(1'b0));
            @(negedge clk);
            chk("steady8", 64'(count), 64'd8);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Stalled head stays stable
        repeat (4) begin
            @(negedge clk);
            chk_req("stall_head", out_req, exp_q[0]);
            chk("stall_cnt", 64'(count), 64'd8);
        end
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1 out_ready = 1'b0;

        // Asynchronous reset with five entries queued
        for (int k = 0; k < 5; k++) send(4'(k), 2'd0, rand_addr(1'b0));
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        chk_en = 0;
        exp_q.delete();
        mdl_cycle = 0; mdl_drop = '0; mdl_dp = 0; mdl_acc = 0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_drop", 64'(drop_cnt), 64'd0);
        chk("arst_cycle", cycle, 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1;

        // Randomized traffic with varying drain pressure
        for (int blk = 0; blk < 10; blk++) begin
            int rdy_pct;
            rdy_pct = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 90 : 55);
            for (int i = 0; i < 100; i++) begin
                in_valid  = ($urandom_range(0, 99) < 70);
                in_core   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15))
                                                        : 4'($urandom_range(0, 11));
                in_opn    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                in_addr   = rand_addr($urandom_range(0, 9) == 0);
                out_ready = ($urandom_range(0, 99) < rdy_pct);
                @(posedge clk);
                #1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("final_empty", 64'(count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
